// File: rtl/j1_io_uart_pkg.sv
// j1_io_uart_pkg: IO address map, status bit positions and UART FSM encoding
package j1_io_uart_pkg;
    localparam logic [15:0] IO_UART_DATA = 16'h1000;
    localparam logic [15:0] IO_UART_STAT = 16'h2000;
    localparam logic [15:0] IO_LEDS      = 16'h0004;
    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_OVERRUN  = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
endpackage

// File: rtl/j1_io_uart_baud_timer.sv
// uart_baud_timer: loadable down-counter; tick is high while the count sits at zero
module uart_baud_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        tick
);
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != 16'd0) cnt <= cnt - 16'd1;
    end
    assign tick = cnt == 16'd0;
endmodule

// File: rtl/j1_io_uart.sv
// j1_io_uart: j1 IO-space peripheral with 8N1 UART, status register and LED register
module j1_io_uart
    import j1_io_uart_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 104,
    parameter int LED_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      mem_addr,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] io_din,
    output logic             uart_tx,
    input  logic             uart_rx,
    output logic [LED_W-1:0] leds
);
    logic [1:0] tx_state, rx_state;
    logic [2:0] tx_bit, rx_bit, status;
    logic [7:0] tx_sh, rx_sh, rx_byte;
    logic tx_ready, rx_valid, overrun, tx_tick, rx_tick;
    logic rx_s0, rx_s1, rx_s2;
    logic wr_data, wr_leds, rd_data, rd_stat, tx_go, rx_fall, rx_done, unused_dout;

    assign wr_data = io_wr && mem_addr == IO_UART_DATA;
    assign wr_leds = io_wr && mem_addr == IO_LEDS;
    assign rd_data = io_rd && mem_addr == IO_UART_DATA;
    assign rd_stat = io_rd && mem_addr == IO_UART_STAT;
    assign tx_go   = wr_data && tx_ready;
    assign rx_fall = rx_s2 && !rx_s1;
    assign rx_done = rx_state == S_STOP && rx_tick && rx_s1;
    assign unused_dout = ^dout;
    assign status[ST_TX_READY] = tx_ready;
    assign status[ST_RX_VALID] = rx_valid;
    assign status[ST_OVERRUN]  = overrun;

    uart_baud_timer tx_timer (
        .clk(clk), .reset(reset),
        .load(tx_go || (tx_state != S_IDLE && tx_tick)),
        .load_val(16'(CLKDIV - 1)), .tick(tx_tick)
    );
    // RX reloads to half a bit on the start edge so later samples land mid-bit
    uart_baud_timer rx_timer (
        .clk(clk), .reset(reset),
        .load(rx_state == S_IDLE ? rx_fall : rx_tick),
        .load_val(rx_state == S_IDLE ? 16'(CLKDIV / 2 - 1) : 16'(CLKDIV - 1)), .tick(rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_ready <= 1'b1;
            uart_tx  <= 1'b1;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else if (tx_go) begin
            tx_state <= S_START;
            tx_ready <= 1'b0;
            uart_tx  <= 1'b0;
            tx_bit   <= '0;
            tx_sh    <= dout[7:0];
        end else if (tx_tick) begin
            case (tx_state)
                S_START: begin
                    tx_state <= S_DATA;
                    uart_tx  <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                end
                S_DATA: begin
                    tx_bit   <= tx_bit + 3'd1;
                    tx_state <= tx_bit == 3'd7 ? S_STOP : S_DATA;
                    uart_tx  <= tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                end
                S_STOP: begin
                    tx_state <= S_IDLE;
                    tx_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {rx_s0, rx_s1, rx_s2} <= 3'b111;
            rx_state <= S_IDLE;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            {rx_s0, rx_s1, rx_s2} <= {uart_rx, rx_s0, rx_s1};
            case (rx_state)
                S_IDLE: rx_state <= rx_fall ? S_START : S_IDLE;
                S_START: if (rx_tick) begin
                    rx_state <= rx_s1 ? S_IDLE : S_DATA;
                    rx_bit   <= '0;
                end
                S_DATA: if (rx_tick) begin
                    rx_sh    <= {rx_s1, rx_sh[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    rx_state <= rx_bit == 3'd7 ? S_STOP : S_DATA;
                end
                S_STOP: rx_state <= rx_tick ? S_IDLE : S_STOP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_din   <= '0;
            leds     <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_done) rx_byte <= rx_sh;
            rx_valid <= rx_done || (rx_valid && !rd_data);
            overrun  <= (rx_done && rx_valid && !rd_data) || (overrun && !rd_stat);
            if (wr_leds) leds <= dout[LED_W-1:0];
            if (io_rd) io_din <= rd_data ? WIDTH'(rx_byte) :
                                 rd_stat ? WIDTH'(status) :
                                 mem_addr == IO_LEDS ? WIDTH'(leds) : '0;
        end
    end
endmodule

// File: tb/tb_j1_io_uart.sv
// tb_j1_io_uart: scoreboard bench for the j1 IO UART/LED peripheral at CLKDIV=4
module tb_j1_io_uart;
    localparam int CLKDIV = 4;
    logic clk = 0, reset = 1, io_rd = 0, io_wr = 0, uart_rx = 1;
    logic [15:0] mem_addr = 0, dout = 0, io_din;
    logic uart_tx;
    logic [7:0] leds;
    int total = 0, bad = 0;
    logic [15:0] exp_q[$], obs_q[$];
    string lbl_q[$];
    logic [7:0] rx_q[$];
    logic tx_q[$];

    always #5 clk = ~clk;

    j1_io_uart #(.WIDTH(16), .CLKDIV(CLKDIV), .LED_W(8)) dut (
        .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr),
        .dout(dout), .io_din(io_din), .uart_tx(uart_tx), .uart_rx(uart_rx), .leds(leds)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string l, input logic [15:0] a, input logic [15:0] e);
        io_rd = 1;
        mem_addr = a;
        step();
        io_rd = 0;
        lbl_q.push_back(l);
        exp_q.push_back(e);
        obs_q.push_back(io_din);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_wr = 1;
        mem_addr = a;
        dout = d;
        step();
        io_wr = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        uart_rx = 0;
        step(CLKDIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            step(CLKDIV);
        end
        uart_rx = stop_bit;
        step(CLKDIV);
        uart_rx = 1;
    endtask

    task automatic test_reset;
        logic [15:0] e, o;
        string l;
        reset = 1;
        step(2);
        total += 3;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        if (leds !== 8'h00) begin bad++; $display("FAIL reset_leds: got %h want 00", leds); end
        if (io_din !== 16'h0) begin bad++; $display("FAIL reset_io_din: got %h want 0000", io_din); end
        reset = 0;
        rd("reset_status", 16'h2000, 16'h0001);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); l = lbl_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s: got %h want %h", l, o, e); end
        end
    endtask

    task automatic test_tx;
        logic [9:0] frame;
        logic e_bit;
        logic [15:0] e, o;
        string l;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++)
            repeat (CLKDIV) tx_q.push_back(frame[k]);
        wr(16'h1000, 16'h00A5);
        for (int i = 0; i < 10 * CLKDIV; i++) begin
            e_bit = tx_q.pop_front();
            total++;
            if (uart_tx !== e_bit) begin bad++; $display("FAIL tx_bit%0d: got %b want %b", i, uart_tx, e_bit); end
            if (i == 12) begin
                total++;
                if (io_din !== 16'h0000) begin bad++; $display("FAIL tx_busy_status: got %h want 0000", io_din); end
            end
            io_wr = (i == 10);
            mem_addr = i == 11 ? 16'h2000 : 16'h1000;
            dout = 16'h00FF;
            io_rd = (i == 11);
            step();
        end
        io_wr = 0;
        io_rd = 0;
        rd("tx_done_status", 16'h2000, 16'h0001);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_idle: got %b want 1", uart_tx); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); l = lbl_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s: got %h want %h", l, o, e); end
        end
    endtask

    task automatic test_rx;
        logic [15:0] e, o;
        string l;
        send(8'h3C, 1);
        rx_q.push_back(8'h3C);
        step(4);
        rd("rx_status", 16'h2000, 16'h0003);
        rd("rx_data", 16'h1000, {8'h00, rx_q.pop_front()});
        rd("rx_status_after", 16'h2000, 16'h0001);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); l = lbl_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s: got %h want %h", l, o, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] e, o;
        logic [7:0] b;
        string l;
        send(8'h11, 1);
        rx_q.push_back(8'h11);
        send(8'h22, 1);
        rx_q.push_back(8'h22);
        step(4);
        rd("overrun_status", 16'h2000, 16'h0007);
        b = rx_q.pop_front();
        b = rx_q.pop_front();
        rd("overrun_data", 16'h1000, {8'h00, b});
        rd("overrun_cleared", 16'h2000, 16'h0001);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); l = lbl_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s: got %h want %h", l, o, e); end
        end
    endtask

    task automatic test_rx_errors;
        logic [15:0] e, o;
        string l;
        uart_rx = 0;
        step();
        uart_rx = 1;
        step(10);
        rd("glitch_status", 16'h2000, 16'h0001);
        send(8'h55, 0);
        step(4);
        rd("framing_status", 16'h2000, 16'h0001);
        send(8'h5A, 1);
        rx_q.push_back(8'h5A);
        step(4);
        rd("recover_status", 16'h2000, 16'h0003);
        rd("recover_data", 16'h1000, {8'h00, rx_q.pop_front()});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); l = lbl_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s: got %h want %h", l, o, e); end
        end
    endtask

    task automatic test_leds_reset;
        logic [15:0] e, o;
        string l;
        wr(16'h0004, 16'hFF5A);
        total++;
        if (leds !== 8'h5A) begin bad++; $display("FAIL leds_write: got %h want 5a", leds); end
        rd("leds_read", 16'h0004, 16'h005A);
        rd("unmapped_read", 16'h0008, 16'h0000);
        wr(16'h1000, 16'h0000);
        step(8);
        total++;
        if (uart_tx !== 1'b0) begin bad++; $display("FAIL midframe_tx: got %b want 0", uart_tx); end
        reset = 1;
        step();
        total += 2;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL abort_tx: got %b want 1", uart_tx); end
        if (leds !== 8'h00) begin bad++; $display("FAIL abort_leds: got %h want 00", leds); end
        reset = 0;
        rd("abort_status", 16'h2000, 16'h0001);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); l = lbl_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s: got %h want %h", l, o, e); end
        end
    endtask

    initial begin
        test_reset;
        test_tx;
        test_rx;
        test_back_to_back;
        test_rx_errors;
        test_leds_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
